// File: rtl/q2_sequencer.sv
// Q2 CPU major-state sequencer: generates s0-s3 and the write strobe ws,
// and gates instruction starts with the front-panel run/step controls.
module q2_sequencer #(
  parameter int ALU_BITS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic step,
  input  logic deref,
  input  logic o0,
  input  logic o1,
  input  logic o2,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic ws,
  output logic busy,
  output logic instr_done
);

  localparam int CW = $clog2(ALU_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(ALU_BITS - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_DEREF = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_ALU   = 3'd4;

  logic [2:0]    st_r, nxt_st_s;
  logic [CW-1:0] cnt_r, nxt_cnt_s;
  logic          ws_r, nxt_ws_s;
  logic          busy_r, nxt_busy_s;
  logic          done_r, nxt_done_s;
  logic [3:0]    s_r, nxt_s_s;
  logic          step_r, step_q;
  logic          step_rise_s;
  logic          unused_opcode_s;

  // o0/o1 are decoded downstream; the sequencer only branches on o2/deref
  assign unused_opcode_s = o0 ^ o1;

  // Major-state code {s3,s2,s1,s0}; non-final ALU bits show the low counter bits
  function automatic logic [3:0] enc_state(input logic [2:0] st, input logic [CW-1:0] cnt);
    logic [1:0] lo;
    lo = 2'(cnt);
    case (st)
      ST_FETCH: enc_state = 4'b0000;
      ST_DEREF: enc_state = 4'b0001;
      ST_LOAD:  enc_state = 4'b0010;
      ST_EXEC:  enc_state = 4'b0011;
      ST_ALU: begin
        if (cnt == CNT_LAST) begin
          enc_state = 4'b1100;
        end else begin
          enc_state = {2'b01, lo};
        end
      end
      default:  enc_state = 4'b0000;
    endcase
  endfunction

  // Step is resampled once, so motion starts one edge after step is first seen
  assign step_rise_s = step_r & ~step_q;

  // Next-state logic: read phase -> write phase, write phase -> next major state
  always_comb begin
    nxt_st_s   = st_r;
    nxt_cnt_s  = cnt_r;
    nxt_ws_s   = ws_r;
    nxt_busy_s = busy_r;
    if (!ws_r) begin
      // busy=0 in FETCH read phase means parked; only run or a step edge releases it
      if ((st_r == ST_FETCH) && !busy_r) begin
        if (run || step_rise_s) begin
          nxt_ws_s   = 1'b1;
          nxt_busy_s = 1'b1;
        end else begin
          nxt_ws_s   = 1'b0;
        end
      end else begin
        nxt_ws_s = 1'b1;
      end
    end else begin
      nxt_ws_s = 1'b0;
      case (st_r)
        ST_FETCH: begin
          if (deref) begin
            nxt_st_s = ST_DEREF;
          end else if (!o2) begin
            nxt_st_s = ST_LOAD;
          end else begin
            nxt_st_s = ST_EXEC;
          end
        end
        ST_DEREF: begin
          if (!o2) begin
            nxt_st_s = ST_LOAD;
          end else begin
            nxt_st_s = ST_EXEC;
          end
        end
        ST_LOAD: begin
          nxt_st_s  = ST_ALU;
          nxt_cnt_s = CNT_ZERO;
        end
        ST_ALU: begin
          if (cnt_r == CNT_LAST) begin
            nxt_st_s   = ST_FETCH;
            nxt_cnt_s  = CNT_ZERO;
            nxt_busy_s = run;
          end else begin
            nxt_cnt_s  = cnt_r + CNT_ONE;
          end
        end
        ST_EXEC: begin
          nxt_st_s   = ST_FETCH;
          nxt_busy_s = run;
        end
        default: begin
          nxt_st_s   = ST_FETCH;
          nxt_cnt_s  = CNT_ZERO;
          nxt_busy_s = 1'b0;
        end
      endcase
    end
    nxt_s_s    = enc_state(nxt_st_s, nxt_cnt_s);
    nxt_done_s = nxt_ws_s && ((nxt_st_s == ST_EXEC) ||
                              ((nxt_st_s == ST_ALU) && (nxt_cnt_s == CNT_LAST)));
  end

  // State, phase, step history and the registered output copies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r   <= ST_FETCH;
      cnt_r  <= CNT_ZERO;
      ws_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      s_r    <= 4'b0000;
      step_r <= 1'b0;
      step_q <= 1'b0;
    end else begin
      st_r   <= nxt_st_s;
      cnt_r  <= nxt_cnt_s;
      ws_r   <= nxt_ws_s;
      busy_r <= nxt_busy_s;
      done_r <= nxt_done_s;
      s_r    <= nxt_s_s;
      step_r <= step;
      step_q <= step_r;
    end
  end

  assign s0         = s_r[0];
  assign s1         = s_r[1];
  assign s2         = s_r[2];
  assign s3         = s_r[3];
  assign ws         = ws_r;
  assign busy       = busy_r;
  assign instr_done = done_r;

endmodule

// File: tb/tb_q2_sequencer.sv
// Scoreboard bench for q2_sequencer: a per-instruction phase-list model
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_q2_sequencer;
  localparam int AB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0, step = 1'b0, deref = 1'b0, o0 = 1'b0, o1 = 1'b0, o2 = 1'b0;
  logic s0, s1, s2, s3, ws, busy, instr_done;

  typedef struct packed {
    logic [3:0] s;
    logic [3:0] m;
    logic       ws;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sbq[$];
  exp_t pend[$];
  exp_t cur;
  logic sa, sb;
  int checks = 0;
  int failures = 0;
  int cyc_no = 0;

  q2_sequencer #(.ALU_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .deref(deref),
    .o0(o0), .o1(o1), .o2(o2), .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .ws(ws), .busy(busy), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] s, input logic [3:0] m,
                              input logic w, input logic b, input logic d);
    exp_t e;
    e.s = s; e.m = m; e.ws = w; e.busy = b; e.done = d;
    return e;
  endfunction

  function automatic exp_t park_e();
    return mk(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic in_fetch_rd(input exp_t e);
    return (e.s == 4'b0000) && (e.ws == 1'b0);
  endfunction

  // Lists every phase of one instruction after its FETCH read phase
  task automatic build();
    logic [3:0] code;
    logic [3:0] msk;
    logic       last;
    pend.delete();
    pend.push_back(mk(4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0));
    if (deref) begin
      pend.push_back(mk(4'b0001, 4'b1111, 1'b0, 1'b1, 1'b0));
      pend.push_back(mk(4'b0001, 4'b1111, 1'b1, 1'b1, 1'b0));
    end
    if (o2) begin
      pend.push_back(mk(4'b0011, 4'b1111, 1'b0, 1'b1, 1'b0));
      pend.push_back(mk(4'b0011, 4'b1111, 1'b1, 1'b1, 1'b1));
    end else begin
      pend.push_back(mk(4'b0010, 4'b1111, 1'b0, 1'b1, 1'b0));
      pend.push_back(mk(4'b0010, 4'b1111, 1'b1, 1'b1, 1'b0));
      for (int i = 0; i < AB; i++) begin
        last = (i == AB - 1);
        code = last ? 4'b1100 : 4'b0100;
        msk  = last ? 4'b1111 : 4'b1100;
        pend.push_back(mk(code, msk, 1'b0, 1'b1, 1'b0));
        pend.push_back(mk(code, msk, 1'b1, 1'b1, last));
      end
    end
  endtask

  // Model step taken at each rising edge with the inputs the DUT samples
  task automatic model_edge();
    logic rise;
    rise = sa & ~sb;
    sb = sa;
    sa = step;
    if (pend.size() > 0) begin
      cur = pend.pop_front();
    end else if (in_fetch_rd(cur)) begin
      if (cur.busy || run || rise) begin
        build();
        cur = pend.pop_front();
      end
    end else begin
      cur = mk(4'b0000, 4'b1111, 1'b0, run, 1'b0);
    end
    sbq.push_back(cur);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc_no++;
  endtask

  task automatic model_reset();
    sbq.delete();
    pend.delete();
    cur = park_e();
    sa = 1'b0;
    sb = 1'b0;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({s3, s2, s1, s0, ws, busy, instr_done} !== 7'b0) begin
      failures++;
      $display("FAIL %s: got s=%b%b%b%b ws=%b busy=%b done=%b, want all 0",
               name, s3, s2, s1, s0, ws, busy, instr_done);
    end
  endtask

  task automatic wait_cond_load_wr(input string name);
    int n;
    n = 0;
    while (!(cur.s == 4'b0010 && cur.ws == 1'b1) && n < 200) begin
      cyc();
      n++;
    end
    checks++;
    if (!(cur.s == 4'b0010 && cur.ws == 1'b1)) begin
      failures++;
      $display("FAIL %s: LOAD write phase not reached within %0d cycles, want reached", name, n);
    end
  endtask

  task automatic drain_to_park(input string name);
    int n;
    n = 0;
    while (!(in_fetch_rd(cur) && !cur.busy) && n < 200) begin
      cyc();
      n++;
    end
    checks++;
    if (!(in_fetch_rd(cur) && !cur.busy)) begin
      failures++;
      $display("FAIL %s: park not reached within %0d cycles, want parked", name, n);
    end
  endtask

  // Monitor: one comparison per cycle against the oldest prediction
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if ((({s3, s2, s1, s0} & e.m) !== (e.s & e.m)) || (ws !== e.ws) ||
          (busy !== e.busy) || (instr_done !== e.done)) begin
        failures++;
        $display("FAIL cycle%0d: got s=%b%b%b%b ws=%b busy=%b done=%b, want s=%b(mask %b) ws=%b busy=%b done=%b",
                 cyc_no, s3, s2, s1, s0, ws, busy, instr_done, e.s, e.m, e.ws, e.busy, e.done);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;

    // Parked with no run/step
    repeat (50) cyc();

    // Continuous EXEC instructions
    deref = 1'b0; o2 = 1'b1; run = 1'b1;
    repeat (16) cyc();

    // Deref + ALU path, then stop
    run = 1'b0;
    drain_to_park("park_after_exec");
    deref = 1'b1; o2 = 1'b0; run = 1'b1;
    repeat (44) cyc();
    run = 1'b0;
    drain_to_park("park_after_alu");

    // Single step; a second step mid-instruction must be ignored
    deref = 1'b0; o2 = 1'b0;
    step = 1'b1; repeat (3) cyc();
    step = 1'b0; repeat (5) cyc();
    step = 1'b1; repeat (2) cyc();
    step = 1'b0; repeat (30) cyc();

    // run falls during ALU bit 3
    run = 1'b1;
    wait_cond_load_wr("wait_load_a");
    repeat (6) cyc();
    run = 1'b0;
    repeat (30) cyc();

    // Async reset at ALU bit 5, away from any clock edge
    run = 1'b1;
    wait_cond_load_wr("wait_load_b");
    repeat (10) cyc();
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset_immediate");
    model_reset();
    run = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("reset_held");
    rst_n = 1'b1;
    repeat (10) cyc();

    // Randomized run/step/opcode traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 29) == 0) run = ~run;
      if ($urandom_range(0, 5) == 0) step = ~step;
      if (in_fetch_rd(cur)) begin
        deref = 1'($urandom_range(0, 1));
        o2 = 1'($urandom_range(0, 1));
        o1 = 1'($urandom_range(0, 1));
        o0 = 1'($urandom_range(0, 1));
      end
      cyc();
    end
    run = 1'b0; step = 1'b0;
    drain_to_park("final_park");
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
